// File: rtl/audio_pkg.sv
// Shared state type, constants and helpers for the audio playback path.
package audio_pkg;

    typedef enum logic [0:0] {PREFILL, PLAY} audio_state_t;

    localparam logic [7:0]  AUDIO_MIDSCALE = 8'h80;
    localparam logic [15:0] CNT_MAX        = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == CNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/audio_fifo.sv
// Single-clock sample FIFO with a first-word fall-through head register.
// Storage is read synchronously so it maps onto block RAM.
module audio_fifo #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_LVL);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_next = pop_ok ? rd_ptr + 1'b1 : rd_ptr;

    // Head tracks the next read address; a write into that slot is forwarded
    // because it can only happen when the FIFO is (or is about to be) empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
        head <= (push_ok && (wr_ptr == rd_next)) ? din : mem[rd_next];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_next;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/audio_player.sv
// Buffers the bursty audio byte stream and plays it out at a fixed sample
// rate as 8-bit PWM, with fill/underrun/overflow statistics for debug.
module audio_player
    import audio_pkg::*;
#(
    parameter int DEPTH      = 4096,
    parameter int PREFILL    = 1024,
    parameter int SAMPLE_DIV = 6250
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     axiiv,
    input  logic [7:0]               axiid,
    input  logic                     mute,
    output logic                     pwm_out,
    output logic                     aud_sd,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     playing,
    output logic [15:0]              underrun_cnt,
    output logic [15:0]              overflow_cnt
);

    localparam int FW = $clog2(DEPTH) + 1;
    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [FW-1:0] PREFILL_LVL = FW'(PREFILL);
    localparam logic [TW-1:0] TICK_AT     = TW'(SAMPLE_DIV - 1);

    audio_state_t  state;
    logic [TW-1:0] sample_cnt;
    logic [7:0]    sample_reg;
    logic [7:0]    duty;
    logic [7:0]    pwm_cnt;
    logic [7:0]    head;
    logic          full;
    logic          empty;
    logic          tick;
    logic          pop;

    assign tick = (state == audio_pkg::PLAY) && (sample_cnt == TICK_AT);
    assign pop  = tick && !empty;

    audio_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (axiiv),
        .pop   (pop),
        .din   (axiid),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (fill)
    );

    // An empty FIFO at a sample tick outputs silence and waits to refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= audio_pkg::PREFILL;
            playing      <= 1'b0;
            sample_cnt   <= '0;
            sample_reg   <= AUDIO_MIDSCALE;
            underrun_cnt <= '0;
        end else begin
            case (state)
                audio_pkg::PREFILL: begin
                    if (fill >= PREFILL_LVL) begin
                        state      <= audio_pkg::PLAY;
                        playing    <= 1'b1;
                        sample_cnt <= '0;
                    end
                end
                audio_pkg::PLAY: begin
                    sample_cnt <= tick ? '0 : sample_cnt + 1'b1;
                    if (tick) begin
                        if (!empty) begin
                            sample_reg <= head;
                        end else begin
                            sample_reg   <= AUDIO_MIDSCALE;
                            underrun_cnt <= sat_inc(underrun_cnt);
                            state        <= audio_pkg::PREFILL;
                            playing      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= audio_pkg::PREFILL;
                    playing <= 1'b0;
                end
            endcase
        end
    end

    // A same-cycle pop frees a slot, so only a push into a full FIFO with no pop is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_cnt <= '0;
        end else if (axiiv && full && !pop) begin
            overflow_cnt <= sat_inc(overflow_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            duty    <= AUDIO_MIDSCALE;
            pwm_out <= 1'b0;
            aud_sd  <= 1'b1;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == 8'hFF) begin
                duty <= sample_reg;
            end
            pwm_out <= !mute && (pwm_cnt < duty);
            aud_sd  <= !mute;
        end
    end

endmodule

// File: tb/tb_audio_player.sv
// Randomised and directed checks of audio_player against a queue-based playback model.
module tb_audio_player;

    localparam int DEPTH      = 8;
    localparam int PREFILL    = 4;
    localparam int SAMPLE_DIV = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   axiiv = 1'b0;
    logic [7:0]             axiid = 8'h00;
    logic                   mute = 1'b0;
    logic                   pwm_out;
    logic                   aud_sd;
    logic [$clog2(DEPTH):0] fill;
    logic                   playing;
    logic [15:0]            underrun_cnt;
    logic [15:0]            overflow_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Playback model: the FIFO is a queue, timing is kept as plain integers.
    byte unsigned m_q[$];
    bit           m_play;
    int           m_timer;
    int           m_sample;
    int           m_duty;
    int           m_pwm_cnt;
    bit           m_pwm;
    bit           m_sd;
    int           m_under;
    int           m_over;

    audio_player #(
        .DEPTH      (DEPTH),
        .PREFILL    (PREFILL),
        .SAMPLE_DIV (SAMPLE_DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .axiiv        (axiiv),
        .axiid        (axiid),
        .mute         (mute),
        .pwm_out      (pwm_out),
        .aud_sd       (aud_sd),
        .fill         (fill),
        .playing      (playing),
        .underrun_cnt (underrun_cnt),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        m_q.delete();
        m_play    = 1'b0;
        m_timer   = 0;
        m_sample  = 128;
        m_duty    = 128;
        m_pwm_cnt = 0;
        m_pwm     = 1'b0;
        m_sd      = 1'b1;
        m_under   = 0;
        m_over    = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit mu);
        int fill_now;
        bit is_tick;
        bit popped;
        fill_now = m_q.size();
        is_tick  = m_play && (m_timer == SAMPLE_DIV - 1);
        popped   = 1'b0;
        m_pwm = !mu && (m_pwm_cnt < m_duty);
        m_sd  = !mu;
        if (m_pwm_cnt == 255) m_duty = m_sample;
        m_pwm_cnt = (m_pwm_cnt + 1) % 256;
        if (!m_play) begin
            if (fill_now >= PREFILL) begin
                m_play  = 1'b1;
                m_timer = 0;
            end
        end else if (is_tick) begin
            m_timer = 0;
            if (fill_now > 0) begin
                m_sample = m_q.pop_front();
                popped   = 1'b1;
            end else begin
                m_sample = 128;
                if (m_under < 65535) m_under++;
                m_play = 1'b0;
            end
        end else begin
            m_timer++;
        end
        if (v) begin
            if (fill_now < DEPTH || popped) m_q.push_back(d[7:0]);
            else if (m_over < 65535) m_over++;
        end
    endtask

    task automatic applyStimulus(input bit v, input int d, input bit mu);
        axiiv = v;
        axiid = d[7:0];
        mute  = mu;
        @(posedge clk);
        if (rst_n) model_step(v, d, mu);
        else model_reset();
        #1;
    endtask

    task automatic do_reset();
        axiiv = 1'b0;
        mute  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_pwm_cnt(input int target, input string tag);
        int n;
        n = 0;
        while (m_pwm_cnt != target && n < 300) begin
            applyStimulus(1'b0, 0, 1'b0);
            n++;
        end
        n_checks++;
        if (m_pwm_cnt != target) begin
            n_fail++;
            $display("[TB] FAIL %s_align: pwm counter alignment timed out after %0d cycles", tag, n);
        end
    endtask

    task automatic test_reset();
        int highs;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, $urandom_range(0, 255), 1'b0);
        n_checks += 6;
        if (fill !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_fill: got %0d expected 0", fill); end
        if (pwm_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pwm: got %b expected 0", pwm_out); end
        if (aud_sd !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_aud_sd: got %b expected 1", aud_sd); end
        if (playing !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_playing: got %b expected 0", playing); end
        if (underrun_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_underrun: got %0d expected 0", underrun_cnt); end
        if (overflow_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_overflow: got %0d expected 0", overflow_cnt); end
        axiiv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 0, 1'b0);
            if (pwm_out === 1'b1) highs++;
        end
        n_checks++;
        if (highs != 128) begin n_fail++; $display("[TB] FAIL reset_duty: got %0d high cycles expected 128", highs); end
    endtask

    task automatic test_prefill_playback();
        int highs;
        wait_pwm_cnt(227, "prefill");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16 * (i + 1), 1'b0);
            n_checks++;
            if (fill !== 4'(i + 1)) begin n_fail++; $display("[TB] FAIL prefill_fill%0d: got %0d expected %0d", i, fill, i + 1); end
        end
        n_checks++;
        if (playing !== 1'b0) begin n_fail++; $display("[TB] FAIL prefill_early_play: got %b expected 0", playing); end
        applyStimulus(1'b0, 0, 1'b0);
        n_checks++;
        if (playing !== 1'b1) begin n_fail++; $display("[TB] FAIL prefill_play_rise: got %b expected 1", playing); end
        for (int i = 0; i < SAMPLE_DIV - 1; i++) applyStimulus(1'b0, 0, 1'b0);
        n_checks++;
        if (fill !== 4'd4) begin n_fail++; $display("[TB] FAIL prefill_no_early_pop: got %0d expected 4", fill); end
        applyStimulus(1'b0, 0, 1'b0);
        n_checks++;
        if (fill !== 4'd3) begin n_fail++; $display("[TB] FAIL prefill_first_pop: got %0d expected 3", fill); end
        wait_pwm_cnt(0, "prefill_wrap");
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 0, 1'b0);
            if (pwm_out === 1'b1) highs++;
        end
        n_checks++;
        if (highs != 16) begin n_fail++; $display("[TB] FAIL prefill_duty_0x10: got %0d high cycles expected 16", highs); end
    endtask

    task automatic test_underrun();
        int highs;
        int n;
        n_checks += 3;
        if (underrun_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL underrun_count: got %0d expected 1", underrun_cnt); end
        if (playing !== 1'b0) begin n_fail++; $display("[TB] FAIL underrun_playing: got %b expected 0", playing); end
        if (fill !== 4'd0) begin n_fail++; $display("[TB] FAIL underrun_fill: got %0d expected 0", fill); end
        wait_pwm_cnt(0, "underrun_wrap");
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 0, 1'b0);
            if (pwm_out === 1'b1) highs++;
        end
        n_checks++;
        if (highs != 128) begin n_fail++; $display("[TB] FAIL underrun_midscale: got %0d high cycles expected 128", highs); end
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, $urandom_range(0, 255), 1'b0);
        n = 0;
        while (playing !== 1'b1 && n < 10) begin
            applyStimulus(1'b0, 0, 1'b0);
            n++;
        end
        n_checks++;
        if (playing !== 1'b1) begin n_fail++; $display("[TB] FAIL underrun_restart: got %b expected 1", playing); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, $urandom_range(0, 255), 1'b0);
        n_checks += 2;
        if (fill !== 4'd8) begin n_fail++; $display("[TB] FAIL overflow_fill: got %0d expected 8", fill); end
        if (overflow_cnt !== 16'd2) begin n_fail++; $display("[TB] FAIL overflow_count: got %0d expected 2", overflow_cnt); end
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'b0, 0, 1'b0);
            n_checks += 2;
            if (pwm_out !== m_pwm) begin n_fail++; $display("[TB] FAIL overflow_play_pwm: cycle %0d got %b expected %b", i, pwm_out, m_pwm); end
            if (fill !== 4'(m_q.size())) begin n_fail++; $display("[TB] FAIL overflow_play_fill: cycle %0d got %0d expected %0d", i, fill, m_q.size()); end
        end
    endtask

    task automatic test_full_push_pop();
        int n;
        do_reset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, $urandom_range(0, 255), 1'b0);
        n_checks += 2;
        if (fill !== 4'd8) begin n_fail++; $display("[TB] FAIL full_fill: got %0d expected 8", fill); end
        if (playing !== 1'b1) begin n_fail++; $display("[TB] FAIL full_playing: got %b expected 1", playing); end
        n = 0;
        while (!(m_play && m_timer == SAMPLE_DIV - 1) && n < 40) begin
            applyStimulus(1'b0, 0, 1'b0);
            n++;
        end
        applyStimulus(1'b1, $urandom_range(0, 255), 1'b0);
        n_checks += 2;
        if (fill !== 4'd8) begin n_fail++; $display("[TB] FAIL full_pushpop_fill: got %0d expected 8", fill); end
        if (overflow_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL full_pushpop_drop: got %0d expected 0", overflow_cnt); end
    endtask

    task automatic test_mute_and_async_reset();
        applyStimulus(1'b0, 0, 1'b1);
        n_checks += 2;
        if (pwm_out !== 1'b0) begin n_fail++; $display("[TB] FAIL mute_pwm: got %b expected 0", pwm_out); end
        if (aud_sd !== 1'b0) begin n_fail++; $display("[TB] FAIL mute_aud_sd: got %b expected 0", aud_sd); end
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 0, 1'b1);
            n_checks += 2;
            if (pwm_out !== 1'b0) begin n_fail++; $display("[TB] FAIL mute_hold_pwm: cycle %0d got %b expected 0", i, pwm_out); end
            if (fill !== 4'(m_q.size())) begin n_fail++; $display("[TB] FAIL mute_drain_fill: cycle %0d got %0d expected %0d", i, fill, m_q.size()); end
        end
        n_checks++;
        if (fill >= 4'd8) begin n_fail++; $display("[TB] FAIL mute_drain: got %0d expected below 8", fill); end
        applyStimulus(1'b0, 0, 1'b0);
        n_checks++;
        if (aud_sd !== 1'b1) begin n_fail++; $display("[TB] FAIL unmute_aud_sd: got %b expected 1", aud_sd); end
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, $urandom_range(0, 255), 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks += 6;
        if (fill !== 4'd0) begin n_fail++; $display("[TB] FAIL async_fill: got %0d expected 0", fill); end
        if (pwm_out !== 1'b0) begin n_fail++; $display("[TB] FAIL async_pwm: got %b expected 0", pwm_out); end
        if (aud_sd !== 1'b1) begin n_fail++; $display("[TB] FAIL async_aud_sd: got %b expected 1", aud_sd); end
        if (playing !== 1'b0) begin n_fail++; $display("[TB] FAIL async_playing: got %b expected 0", playing); end
        if (underrun_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL async_underrun: got %0d expected 0", underrun_cnt); end
        if (overflow_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL async_overflow: got %0d expected 0", overflow_cnt); end
        axiiv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        int rates[6] = '{3, 10, 40, 6, 0, 90};
        bit mu;
        bit v;
        mu = 1'b0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 99) < rates[(i / 500) % 6]);
            if ($urandom_range(0, 99) == 0) mu = !mu;
            applyStimulus(v, $urandom_range(0, 255), mu);
            n_checks += 6;
            if (fill !== 4'(m_q.size())) begin n_fail++; $display("[TB] FAIL rand_fill: cycle %0d got %0d expected %0d", i, fill, m_q.size()); end
            if (playing !== m_play) begin n_fail++; $display("[TB] FAIL rand_playing: cycle %0d got %b expected %b", i, playing, m_play); end
            if (pwm_out !== m_pwm) begin n_fail++; $display("[TB] FAIL rand_pwm: cycle %0d got %b expected %b", i, pwm_out, m_pwm); end
            if (aud_sd !== m_sd) begin n_fail++; $display("[TB] FAIL rand_aud_sd: cycle %0d got %b expected %b", i, aud_sd, m_sd); end
            if (underrun_cnt !== 16'(m_under)) begin n_fail++; $display("[TB] FAIL rand_underrun: cycle %0d got %0d expected %0d", i, underrun_cnt, m_under); end
            if (overflow_cnt !== 16'(m_over)) begin n_fail++; $display("[TB] FAIL rand_overflow: cycle %0d got %0d expected %0d", i, overflow_cnt, m_over); end
        end
    endtask

    initial begin
        test_reset();
        test_prefill_playback();
        test_underrun();
        test_overflow();
        test_full_push_pop();
        test_mute_and_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_player.md
Name: audio_player

Overview:
- Consumes the 8-bit audio byte stream from image_audio_splitter on the 50 MHz ethernet clock domain.
- Absorbs bursty packet arrival in a FIFO, then plays samples out at a fixed rate as 8-bit PWM to the board audio amplifier.
- Sits beside frame_packager as the second consumer of splitter output.
- Reports fill level, underrun and overflow statistics for LED/seven-segment debug.

Parameters:
- DEPTH, 4096, FIFO depth in samples; power of two.
- PREFILL, 1024, FIFO count required before playback starts or resumes.
- SAMPLE_DIV, 6250, clk cycles per sample; 50 MHz / 6250 = 8 kHz.

Ports:
- clk  in  1  eth_refclk, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- axiiv  in  1  audio byte valid; one byte per asserted cycle.
- axiid  in  8  audio sample, unsigned, midscale 0x80.
- mute  in  1  silences output while high.
- pwm_out  out  1  PWM audio signal (aud_pwm).
- aud_sd  out  1  amplifier enable, high = on.
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy.
- playing  out  1  high in PLAY state.
- underrun_cnt  out  16  saturating count of underruns.
- overflow_cnt  out  16  saturating count of dropped bytes.

Behaviour:
- Reset is asynchronous, active-low. All outputs and state are 0 except aud_sd, which is 1; state is PREFILL; sample_reg and duty are 0x80; the FIFO is empty.
- No input ready signal: the upstream block cannot stall. Any byte presented while the FIFO is full is dropped, and overflow_cnt increments, saturating at 0xFFFF.
- Pop and push in the same cycle: both take effect, including when the FIFO is full (the pop makes room) and when it is empty (the pushed byte is not the popped one; the pop is then an underrun). fill is updated the next cycle.
- State machine:
  - PREFILL: pops nothing. Moves to PLAY on the cycle after fill >= PREFILL, clearing the sample counter.
  - PLAY: sample counter runs 0..SAMPLE_DIV-1; the tick is the cycle where counter == SAMPLE_DIV-1.
    - Tick with FIFO non-empty: pop head into sample_reg.
    - Tick with FIFO empty: sample_reg <= 0x80, underrun_cnt++ (saturating), state -> PREFILL.
- The first pop occurs SAMPLE_DIV cycles after entering PLAY.
- PWM:
  - pwm_cnt is an 8-bit free-running counter that wraps 255 -> 0.
  - duty <= sample_reg only on the cycle pwm_cnt == 255, so there are no glitches mid-period.
  - pwm_out is registered as (pwm_cnt < duty), giving one cycle of latency from pwm_cnt to pin.
  - duty 0x00 gives a constant 0; 0xFF gives 255/256 high.
- mute=1 forces pwm_out=0 and aud_sd=0 on the next cycle. The FIFO, state machine and counters keep running, so unmuting resumes in stream position.
- playing = (state == PLAY), registered.
- The FIFO uses pointer wrap-around modulo DEPTH. fill never exceeds DEPTH.

Decomposition:
- audio_pkg holds:
  - typedef enum logic [0:0] {PREFILL, PLAY} audio_state_t;
  - localparam AUDIO_MIDSCALE = 8'h80;
  - localparam CNT_MAX = 16'hFFFF.
- One sub-module, audio_fifo: a synchronous single-clock FIFO with push/pop/full/empty/count and first-word fall-through head. Its storage is inferred as BRAM.
- audio_player contains the state machine, sample timer, PWM and statistics.

Test Plan:
All scenarios use DEPTH=8, PREFILL=4, SAMPLE_DIV=16.
- Reset: hold rst_n=0, push bytes -> fill=0, pwm_out=0, aud_sd=1, playing=0. Release; pwm_out shows a 128/256 duty.
- Prefill/playback: push 0x10,0x20,0x30,0x40 on consecutive cycles -> playing rises the cycle after fill reaches 4. 0x10 pops 16 cycles later. After the next pwm_cnt wrap, pwm_out is high for exactly 16 of 256 cycles.
- Underrun: after the 4 bytes drain with no further input, the next tick -> duty 0x80, underrun_cnt=1, playing=0. Pushing 4 more bytes restarts playback.
- Overflow: push 10 bytes back-to-back in PREFILL -> fill=8, overflow_cnt=2. The bytes played are the first 8 in order.
- Full with simultaneous push/pop: fill=8 in PLAY, push on a tick cycle -> no drop, overflow_cnt unchanged, fill stays 8.
- Mute and async reset: mute=1 mid-playback -> pwm_out=0 and aud_sd=0 next cycle, while fill keeps decreasing. Assert rst_n=0 mid-period, asynchronously to clk -> outputs reach reset values immediately.
